// File: rtl/tri_fifo_if.sv
// Triangle stream bundle: the upstream push side and the downstream pop side of tri_fifo.
// The FIFO takes the slave modport; whatever drives and consumes triangles takes master.
interface tri_fifo_if #(
   parameter int WIDTH = 32
);
   logic [9*WIDTH-1:0] tri_in;
   logic               last_in;
   logic               valid_in;
   logic               ready_out;
   logic [9*WIDTH-1:0] tri_out;
   logic               last_out;
   logic               valid_out;
   logic               ready_in;

   modport slave (
      input  tri_in, last_in, valid_in, ready_in,
      output ready_out, tri_out, last_out, valid_out
   );

   modport master (
      output tri_in, last_in, valid_in, ready_in,
      input  ready_out, tri_out, last_out, valid_out
   );
endinterface

// File: rtl/tri_fifo.sv
// First-word-fall-through FIFO of triangles (nine coordinates plus an end-of-object flag)
// with object counting, an almost-full threshold and a sticky overflow flag.
module tri_fifo #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   flush_in,
   tri_fifo_if.slave              bus,
   output logic [$clog2(DEPTH):0] count_out,
   output logic                   almost_full_out,
   output logic                   overflow_out,
   output logic [$clog2(DEPTH):0] obj_count_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = 9 * WIDTH;

   logic [TW:0]    mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  obj_cnt_q, obj_cnt_d;
   logic           ovf_q, ovf_d;
   logic           full, empty, push, pop;
   logic [AW-1:0]  wr_idx, rd_idx;
   logic [TW:0]    head;

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   // Same slot with opposite wrap bits means the writer is a full lap ahead.
   assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign empty  = (wr_ptr_q == rd_ptr_q);

   // Pointers run modulo 2*DEPTH, so their difference is the occupancy 0..DEPTH.
   assign count_out       = wr_ptr_q - rd_ptr_q;
   assign almost_full_out = (count_out >= PW'(AF_LEVEL));
   assign overflow_out    = ovf_q;
   assign obj_count_out   = obj_cnt_q;

   assign bus.ready_out = !full;
   assign bus.valid_out = !empty;
   assign head          = mem_q[rd_idx];
   assign bus.tri_out   = head[TW-1:0];
   assign bus.last_out  = head[TW];

   assign push = bus.valid_in && !full;
   assign pop  = !empty && bus.ready_in;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      obj_cnt_d = obj_cnt_q;
      ovf_d     = ovf_q | (bus.valid_in & full);
      if (flush_in) begin
         rd_ptr_d  = wr_ptr_q;
         obj_cnt_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if ((push && bus.last_in) && !(pop && bus.last_out)) begin
            obj_cnt_d = obj_cnt_q + PW'(1);
         end else if (!(push && bus.last_in) && (pop && bus.last_out)) begin
            obj_cnt_d = obj_cnt_q - PW'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         obj_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         obj_cnt_q <= obj_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage carries no reset; only the pointers decide what is valid.
   always_ff @(posedge clk_in) begin
      if (rst_in && push && !flush_in) begin
         mem_q[wr_idx] <= {bus.last_in, bus.tri_in};
      end
   end
endmodule

// File: tb/tb_tri_fifo.sv
// Directed and randomized stimulus for tri_fifo, checked against a queue model of the FIFO.
module tb_tri_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int AFL   = 2;
   localparam int TW    = 9 * WIDTH;

   logic clk_in, rst_in, flush_in;
   logic [2:0] count_out, obj_count_out;
   logic almost_full_out, overflow_out;

   tri_fifo_if #(.WIDTH(WIDTH)) bus ();

   tri_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .flush_in        (flush_in),
      .bus             (bus.slave),
      .count_out       (count_out),
      .almost_full_out (almost_full_out),
      .overflow_out    (overflow_out),
      .obj_count_out   (obj_count_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   typedef struct packed {
      logic          last;
      logic [TW-1:0] t;
   } ent_t;

   ent_t q[$];
   logic m_ovf;
   int   total = 0;
   int   bad   = 0;
   int   tag_k = 0;

   task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, tag_k, obs, exp);
      end
   endtask

   function automatic logic [TW-1:0] mk_tri(input int k);
      logic [TW-1:0] t;
      for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
      t[31:0] = 32'h3F80_0000 + k;
      return t;
   endfunction

   function automatic int obj_model();
      int n = 0;
      foreach (q[i]) if (q[i].last) n++;
      return n;
   endfunction

   task automatic check_all();
      chk("count", TW'(count_out), TW'(q.size()));
      chk("obj_count", TW'(obj_count_out), TW'(obj_model()));
      chk("overflow", TW'(overflow_out), TW'(m_ovf));
      chk("valid_out", TW'(bus.valid_out), TW'(q.size() != 0));
      chk("ready_out", TW'(bus.ready_out), TW'(q.size() != DEPTH));
      chk("almost_full", TW'(almost_full_out), TW'(q.size() >= AFL));
      if (q.size() != 0) begin
         chk("tri_out", bus.tri_out, q[0].t);
         chk("last_out", TW'(bus.last_out), TW'(q[0].last));
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic step(input logic v, input logic l, input logic [TW-1:0] t,
                       input logic r, input logic f, input logic rs);
      int  sz;
      bit  do_push, do_pop;
      bus.valid_in = v;
      bus.last_in  = l;
      bus.tri_in   = t;
      bus.ready_in = r;
      flush_in     = f;
      rst_in       = rs;
      @(posedge clk_in);
      sz = q.size();
      if (!rs) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (v && sz == DEPTH) m_ovf = 1'b1;
         if (f) begin
            q.delete();
         end else begin
            do_pop  = (sz > 0) && r;
            do_push = v && (sz < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{last: l, t: t});
         end
      end
      #1;
      tag_k++;
      check_all();
   endtask

   task automatic idle(input logic r);
      step(1'b0, 1'b0, mk_tri(99), r, 1'b0, 1'b1);
   endtask

   initial begin
      logic [TW-1:0] t4;
      m_ovf = 1'b0;
      bus.valid_in = 1'b0; bus.last_in = 1'b0; bus.tri_in = '0; bus.ready_in = 1'b0;
      flush_in = 1'b0; rst_in = 1'b0;

      // Reset held several cycles with traffic offered, then first push on release.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, mk_tri(50), 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, mk_tri(0), 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, mk_tri(0), 1'b1, 1'b0, 1'b1);

      // Fill T0..T3 with no consumer.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, mk_tri(k), 1'b0, 1'b0, 1'b1);
      chk("full_head_v1x", TW'(bus.tri_out[31:0]), TW'(32'h3F80_0000));

      // Push into a full FIFO, then drain; T4 must never show up.
      step(1'b1, 1'b0, mk_tri(4), 1'b0, 1'b0, 1'b1);
      chk("overflow_set", TW'(overflow_out), TW'(1'b1));
      for (int k = 0; k < 4; k++) begin
         chk("drain_order", TW'(bus.tri_out[31:0]), TW'(32'h3F80_0000 + k));
         idle(1'b1);
      end

      // Full with simultaneous pop and offered push: push refused, accepted next cycle.
      for (int k = 0; k < 4; k++) step(1'b1, 1'b0, mk_tri(k), 1'b0, 1'b0, 1'b1);
      t4 = mk_tri(4);
      step(1'b1, 1'b0, t4, 1'b1, 1'b0, 1'b1);
      chk("full_pop_count", TW'(count_out), TW'(3));
      step(1'b1, 1'b0, t4, 1'b0, 1'b0, 1'b1);
      chk("refused_then_ok", TW'(count_out), TW'(4));

      // Steady push+pop at occupancy 2 across the pointer wrap.
      idle(1'b1);
      idle(1'b1);
      for (int k = 10; k < 20; k++) step(1'b1, 1'b0, mk_tri(k), 1'b1, 1'b0, 1'b1);
      chk("steady_count", TW'(count_out), TW'(2));

      // Object markers, then flush keeps the sticky overflow.
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 1'b0, mk_tri(0), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, mk_tri(1), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, mk_tri(2), 1'b0, 1'b0, 1'b1);
      chk("obj_two", TW'(obj_count_out), TW'(2));
      idle(1'b1);
      chk("last_second", TW'(bus.last_out), TW'(1'b1));
      idle(1'b1);
      chk("obj_one", TW'(obj_count_out), TW'(1));
      step(1'b1, 1'b1, mk_tri(3), 1'b1, 1'b1, 1'b1);
      chk("flush_ovf_kept", TW'(overflow_out), TW'(1'b1));

      // Mid-stream reset with a push offered.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, mk_tri(k), 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, mk_tri(7), 1'b1, 1'b0, 1'b0);
      chk("rst_count", TW'(count_out), TW'(0));

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), mk_tri(100 + i),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 59) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tri_fifo.md
TRI_FIFO -- requirements
Module: tri_fifo

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one vertex coordinate (IEEE-754 single).
REQ-002 Parameter DEPTH, default 16, triangle entries stored; power of two, 2..256.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full_out asserts.
REQ-004 clk_in  input  1  sole clock; all state on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 flush_in  input  1  discard all stored entries.
REQ-007 tri_in  input  9*WIDTH  triangle {v3.z,v3.y,v3.x,v2.z,v2.y,v2.x,v1.z,v1.y,v1.x}, v1.x in LSBs.
REQ-008 last_in  input  1  triangle is the final triangle of the object (obj_done marker).
REQ-009 valid_in  input  1  upstream offers tri_in/last_in.
REQ-010 ready_out  output  1  FIFO can accept an entry this cycle.
REQ-011 tri_out  output  9*WIDTH  head-entry triangle, same packing as tri_in.
REQ-012 last_out  output  1  last flag of head entry.
REQ-013 valid_out  output  1  head entry valid.
REQ-014 ready_in  input  1  downstream consumes head entry.
REQ-015 count_out  output  $clog2(DEPTH)+1  entries stored, 0..DEPTH.
REQ-016 almost_full_out  output  1  count_out >= AF_LEVEL.
REQ-017 overflow_out  output  1  sticky: push attempted while full.
REQ-018 obj_count_out  output  $clog2(DEPTH)+1  stored entries with last flag set.

Function
REQ-019 Push occurs on a cycle with valid_in && ready_out; pop on a cycle with valid_out && ready_in.
REQ-020 ready_out shall equal (count_out != DEPTH); combinational from registered count only, never from valid_in.
REQ-021 valid_out shall equal (count_out != 0); first-word-fall-through: tri_out/last_out show the head entry with no read latency.
REQ-022 Write-to-read latency one cycle: entry pushed at edge N appears on tri_out with valid_out high after edge N.
REQ-023 Storage: DEPTH x (9*WIDTH+1) register array; write and read pointers $clog2(DEPTH)+1 bits, MSB used as wrap bit; full when indices equal and wrap bits differ, empty when pointers equal.
REQ-024 Pointers increment modulo 2*DEPTH; index DEPTH-1 wraps to 0 with wrap bit toggled.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH: both occur, count_out unchanged.
REQ-026 When empty, a push with ready_in high is stored, not bypassed; valid_out rises next cycle.
REQ-027 When full, pop with valid_in high: pop occurs, push refused (ready_out low that cycle), count_out = DEPTH-1 next cycle.
REQ-028 valid_in high while full sets overflow_out next cycle; data discarded; pointers unchanged.
REQ-029 overflow_out cleared only by reset.
REQ-030 obj_count_out increments on push with last_in=1, decrements on pop with last_out=1, unchanged when both occur.
REQ-031 tri_out/last_out are don't-care while valid_out low; bench shall not check them then.
REQ-032 flush_in has priority over push and pop: next cycle pointers equal, count_out=0, obj_count_out=0; overflow_out retained.
REQ-033 Array contents not reset; only pointers, counters, flags.

Reset
REQ-034 rst_in=0 at a rising edge: next cycle count_out=0, obj_count_out=0, valid_out=0, ready_out=1, almost_full_out=0 (AF_LEVEL>0), overflow_out=0.
REQ-035 Reset overrides flush, push and pop; mid-stream reset discards all entries.
REQ-036 Reset held for multiple cycles keeps outputs at reset values; first push accepted on the first edge with rst_in=1.

Verification (DEPTH=4, AF_LEVEL=2, WIDTH=32)
REQ-037 Push T0..T3 (v1.x=0x3F800000+k), ready_in=0 -> count_out 1,2,3,4; almost_full_out from count 2; ready_out=0 at 4; tri_out=T0.
REQ-038 Full, valid_in=1 with T4, ready_in=0 -> overflow_out=1 next cycle, count_out=4; then drain 4 pops -> T0,T1,T2,T3 in order, T4 never appears.
REQ-039 Full, valid_in=1 and ready_in=1 -> T0 popped, T4 refused, count_out=3; next cycle T4 accepted, count_out=4.
REQ-040 Steady push+pop for 10 cycles at count=2 -> count_out stays 2, order preserved across pointer wrap (index 3->0).
REQ-041 Push T0,T1(last=1),T2(last=1) -> obj_count_out=2; pop T0,T1 -> last_out 0 then 1, obj_count_out=1; flush_in=1 -> count_out=0, obj_count_out=0, overflow_out unchanged.
REQ-042 Three entries stored, rst_in=0 one cycle with valid_in=1 -> all REQ-034 values next cycle; no entry stored.
